tic_tac_toe_game_ctrl: RTL
==========================

# tic_tac_toe_game_ctrl

Game controller for the tic-tac-toe design: it sits downstream of the cursor input stage and upstream of the display. It takes the cursor position and a one-cycle place pulse and holds the X/O board registers. It feeds the occupied-cell mask back to the cursor stage, alternates players and declares win or draw through a small state machine.

## Interface
- FIRST_PLAYER, default 0: player who moves first after reset/new_game (0 = X, 1 = O).
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cell_cursor  in  4  selected cell, 0..8 row-major (row = i/3, col = i%3); 9..15 invalid.
- place  in  1  one-cycle pulse: mark the cursor cell for the current player.
- new_game  in  1  one-cycle pulse: clear board, restart.
- grid_x  out  9  cells held by X (bit i = cell i).
- grid_o  out  9  cells held by O.
- grid_state_marked  out  9  grid_x | grid_o; drives the cursor stage.
- player_turn  out  1  player to move (0 = X, 1 = O).
- game_over  out  1  high in WIN_X, WIN_O, DRAW.
- winner  out  2  00 none, 01 X, 10 O, 11 draw.
- win_line  out  9  mask of the completed line when winner is 01/10, else 0.
- move_count  out  4  accepted moves since start, 0..9.
- illegal_move  out  1  one-cycle pulse on a rejected place.

## Operation
- States: PLAY, CHECK, WIN_X, WIN_O, DRAW.
- Reset values:
  - grid_x = grid_o = 0; move_count = 0; winner = 00; win_line = 0; illegal_move = 0.
  - player_turn = FIRST_PLAYER; state PLAY.
- PLAY with place:
  - Legal move (cursor ≤ 8 and cell unmarked): set bit in grid_x or grid_o per player_turn, move_count += 1, go to CHECK.
  - Illegal move (cursor ≥ 9 or cell marked): illegal_move = 1 for one cycle; no other change; stay in PLAY.
- CHECK: evaluate the board of the player who just moved against the 8 line masks 0x007, 0x038, 0x1C0, 0x049, 0x092, 0x124, 0x111, 0x054.
  - Win: go to WIN_X/WIN_O, set winner, set win_line to the lowest-indexed matching mask.
  - No win and move_count == 9: go to DRAW, winner = 11.
  - Otherwise: toggle player_turn, return to PLAY.
  - A win on the 9th move is a win, not a draw.
- place during CHECK, WIN_X, WIN_O or DRAW: ignored, no illegal_move pulse.
- new_game in any state: restores reset values (player_turn = FIRST_PLAYER) on the next edge; new_game has priority over a simultaneous place.
- move_count saturates at 9 by construction; it never wraps.

## Timing
- place sampled at edge n:
  - Grid bit, grid_state_marked and move_count update at edge n.
  - State is CHECK during cycle n..n+1.
  - winner/game_over or the new player_turn update at edge n+1.
- Place-to-result latency: 2 edges.
- illegal_move asserts at edge n and deasserts at edge n+1.
- A place arriving the cycle after an accepted place (state CHECK) is dropped; upstream pulses are human-rate.
- grid_state_marked is the combinational OR of registered outputs, with no extra latency, so the cursor stage sees the new mark one cycle after place.
- Reset asserted mid-game clears everything asynchronously; the first legal place after release is handled normally.

## Structure
- Package ttt_pkg holds:
  - the state encoding;
  - the winner codes (NONE, X, O, DRAW);
  - the 8 line masks as a constant array;
  - the cell count 9.
- Sub-module ttt_win_detect: combinational; 9-bit board in, win flag and 9-bit line mask out (lowest-indexed match). Instantiated once, fed by the mover's board.
- The remainder is one FSM plus the board registers in the top module.

## Test plan
- X wins row 0:
  - Stimulus: reset; places at cursor 0(X), 3(O), 1(X), 4(O), 2(X).
  - Required: after the last place + 2 edges, winner = 01, win_line = 0x007, game_over = 1, move_count = 5, grid_x = 0x007, grid_o = 0x018.
- Draw:
  - Stimulus: places 0, 1, 2, 4, 3, 5, 7, 6, 8.
  - Required: winner = 11, win_line = 0, grid_x = 0x18D, grid_o = 0x072, move_count = 9.
- Illegal moves:
  - Stimulus: place at 4 (X), then place at 4 again, then place at cursor 12.
  - Required: illegal_move pulses once each time; grid and move_count (1) unchanged; player_turn stays 1.
- Dropped and post-game places:
  - Stimulus: place during CHECK; place after WIN_X.
  - Required: no grid change and no illegal_move pulse.
- Last-move win, restart and reset:
  - Stimulus: X completes diagonal 0x054 on move 9.
  - Required: winner = 01, not draw.
  - Stimulus: then new_game asserted together with place.
  - Required: board clear, move_count = 0, player_turn = FIRST_PLAYER, state PLAY.
  - Stimulus: assert reset mid-game.
  - Required: all outputs at reset values immediately.

Source files
------------

// File: rtl/ttt_pkg.sv
// ---------------------------------------------------------------------------
// ttt_pkg
// Shared definitions for the tic-tac-toe game controller:
//   state_t     - controller FSM states
//   winner_t    - winner output codes (none / X / O / draw)
//   NUM_CELLS   - number of board cells (9)
//   NUM_LINES   - number of winning lines (8)
//   LINE_MASKS  - the 8 winning-line masks, in priority order
// ---------------------------------------------------------------------------
package ttt_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;

    typedef enum logic [2:0] {
        ST_PLAY,
        ST_CHECK,
        ST_WIN_X,
        ST_WIN_O,
        ST_DRAW
    } state_t;

    typedef enum logic [1:0] {
        WNR_NONE = 2'b00,
        WNR_X    = 2'b01,
        WNR_O    = 2'b10,
        WNR_DRAW = 2'b11
    } winner_t;

    // Rows, columns, then the two diagonals; index 0 has the highest priority.
    localparam logic [NUM_CELLS-1:0] LINE_MASKS [NUM_LINES] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

endpackage

// File: rtl/ttt_win_detect.sv
// ---------------------------------------------------------------------------
// ttt_win_detect
// Combinational win detector for one player's board.
//   i_board [8:0] : cells held by the player (bit i = cell i)
//   o_win         : board contains at least one complete line
//   o_line  [8:0] : mask of the lowest-indexed complete line, 0 if none
// ---------------------------------------------------------------------------
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [NUM_CELLS-1:0] i_board,
    output logic                 o_win,
    output logic [NUM_CELLS-1:0] o_line
);

    logic w_hit;

    always_comb begin
        w_hit  = 1'b0;
        o_line = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if (!w_hit && ((i_board & LINE_MASKS[i]) == LINE_MASKS[i])) begin
                w_hit  = 1'b1;
                o_line = LINE_MASKS[i];
            end
        end
        o_win = w_hit;
    end

endmodule

// File: rtl/tic_tac_toe_game_ctrl.sv
// ---------------------------------------------------------------------------
// tic_tac_toe_game_ctrl
// Game controller: holds the X/O boards, alternates players and declares
// win or draw.
//   FIRST_PLAYER          : player moving first after reset/new_game (0=X, 1=O)
//   CLOCK_50              : system clock, rising edge
//   reset                 : asynchronous active-high reset
//   cell_cursor [3:0]     : selected cell 0..8 (9..15 invalid)
//   place                 : one-cycle pulse, mark cursor cell for current player
//   new_game              : one-cycle pulse, clear board and restart
//   grid_x / grid_o [8:0] : cells held by X / O
//   grid_state_marked[8:0]: grid_x | grid_o, fed back to the cursor stage
//   player_turn           : player to move (0=X, 1=O)
//   game_over             : high in WIN_X, WIN_O, DRAW
//   winner [1:0]          : 00 none, 01 X, 10 O, 11 draw
//   win_line [8:0]        : completed line mask on a win, else 0
//   move_count [3:0]      : accepted moves since start, 0..9
//   illegal_move          : one-cycle pulse on a rejected place
// ---------------------------------------------------------------------------
module tic_tac_toe_game_ctrl
    import ttt_pkg::*;
#(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [3:0]           cell_cursor,
    input  logic                 place,
    input  logic                 new_game,
    output logic [NUM_CELLS-1:0] grid_x,
    output logic [NUM_CELLS-1:0] grid_o,
    output logic [NUM_CELLS-1:0] grid_state_marked,
    output logic                 player_turn,
    output logic                 game_over,
    output logic [1:0]           winner,
    output logic [NUM_CELLS-1:0] win_line,
    output logic [3:0]           move_count,
    output logic                 illegal_move
);

    state_t               r_state;
    state_t               w_state_next;
    logic [NUM_CELLS-1:0] r_grid_x;
    logic [NUM_CELLS-1:0] r_grid_o;
    logic [3:0]           r_move_count;
    logic                 r_player_turn;
    winner_t              r_winner;
    logic [NUM_CELLS-1:0] r_win_line;
    logic                 r_illegal_move;

    logic [NUM_CELLS-1:0] w_marked;
    logic [NUM_CELLS-1:0] w_cell_onehot;
    logic                 w_legal;
    logic [NUM_CELLS-1:0] w_mover_board;
    logic                 w_win;
    logic [NUM_CELLS-1:0] w_win_line;
    logic                 w_board_full;

    assign w_marked      = r_grid_x | r_grid_o;
    // Cursors 9..15 shift the bit out of the 9-bit field, giving zero.
    assign w_cell_onehot = 9'd1 << cell_cursor;
    assign w_legal       = (cell_cursor < 4'(NUM_CELLS)) && ((w_cell_onehot & w_marked) == '0);
    // During CHECK player_turn has not toggled yet, so it still names the mover.
    assign w_mover_board = r_player_turn ? r_grid_o : r_grid_x;
    assign w_board_full  = (r_move_count == 4'(NUM_CELLS));

    ttt_win_detect u_win_detect (
        .i_board (w_mover_board),
        .o_win   (w_win),
        .o_line  (w_win_line)
    );

    // State register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= ST_PLAY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (new_game) begin
            w_state_next = ST_PLAY;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (place && w_legal) begin
                        w_state_next = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_win) begin
                        w_state_next = r_player_turn ? ST_WIN_O : ST_WIN_X;
                    end else if (w_board_full) begin
                        w_state_next = ST_DRAW;
                    end else begin
                        w_state_next = ST_PLAY;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // Board and result registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_grid_x       <= '0;
            r_grid_o       <= '0;
            r_move_count   <= '0;
            r_player_turn  <= FIRST_PLAYER;
            r_winner       <= WNR_NONE;
            r_win_line     <= '0;
            r_illegal_move <= 1'b0;
        end else begin
            r_illegal_move <= 1'b0;
            if (new_game) begin
                r_grid_x      <= '0;
                r_grid_o      <= '0;
                r_move_count  <= '0;
                r_player_turn <= FIRST_PLAYER;
                r_winner      <= WNR_NONE;
                r_win_line    <= '0;
            end else begin
                case (r_state)
                    ST_PLAY: begin
                        if (place) begin
                            if (w_legal) begin
                                if (r_player_turn) begin
                                    r_grid_o <= r_grid_o | w_cell_onehot;
                                end else begin
                                    r_grid_x <= r_grid_x | w_cell_onehot;
                                end
                                r_move_count <= r_move_count + 4'd1;
                            end else begin
                                r_illegal_move <= 1'b1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (w_win) begin
                            r_winner   <= r_player_turn ? WNR_O : WNR_X;
                            r_win_line <= w_win_line;
                        end else if (w_board_full) begin
                            r_winner <= WNR_DRAW;
                        end else begin
                            r_player_turn <= ~r_player_turn;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs
    always_comb begin
        grid_x            = r_grid_x;
        grid_o            = r_grid_o;
        grid_state_marked = w_marked;
        player_turn       = r_player_turn;
        winner            = r_winner;
        win_line          = r_win_line;
        move_count        = r_move_count;
        illegal_move      = r_illegal_move;
        game_over         = (r_state == ST_WIN_X) || (r_state == ST_WIN_O) || (r_state == ST_DRAW);
    end

endmodule
